// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, the r0 index and the simm13 sign extension.
package operand_fetch_stage_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int SIMM_W = 13;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    function automatic logic [DATA_W-1:0] sign_extend_simm(input logic [SIMM_W-1:0] s);
        return {{(DATA_W-SIMM_W){s[SIMM_W-1]}}, s};
    endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: decoder-to-operand-fetch valid/ready channel.
interface operand_fetch_stage_if;
    import operand_fetch_stage_pkg::*;
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              i;
    logic [SIMM_W-1:0] simm;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, rs1, rs2, rd, i, simm, ctrl, input ready);
    modport slave  (input valid, rs1, rs2, rd, i, simm, ctrl, output ready);
endinterface

// File: rtl/operand_fetch_stage_bypass_mux.sv
// operand_bypass_mux: picks one source operand from r0, EX forward, WB bypass or file data.
module operand_bypass_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_en,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op
);
    // EX is the newer producer, so it outranks WB.
    assign op = (idx == REG_ZERO)          ? '0      :
                (ex_en && ex_rd == idx)    ? ex_data :
                (wb_we && wb_rd == idx)    ? wb_data : rf_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: builds forwarded operands, stalls on load-use, and registers them into ID/EX.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_stage_if.slave dec,
    output logic [ADDR_W-1:0]    rf_addr_a,
    output logic [ADDR_W-1:0]    rf_addr_b,
    input  logic [DATA_W-1:0]    rf_pa,
    input  logic [DATA_W-1:0]    rf_pb,
    input  logic                 ex_fwd_valid,
    input  logic                 ex_fwd_we,
    input  logic                 ex_fwd_load,
    input  logic [ADDR_W-1:0]    ex_fwd_rd,
    input  logic [DATA_W-1:0]    ex_fwd_data,
    input  logic                 wb_we,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_op_a,
    output logic [DATA_W-1:0]    out_op_b,
    output logic [ADDR_W-1:0]    out_rd,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [CNT_W-1:0]     stall_cnt
);
    logic              ex_alu;
    logic              hazard;
    logic              adv;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] byp_b;
    logic [DATA_W-1:0] op_b;

    assign rf_addr_a = dec.rs1;
    assign rf_addr_b = dec.rs2;
    // A load's result is not ready yet, so it is never forwarded; it stalls instead.
    assign ex_alu    = ex_fwd_valid && ex_fwd_we && !ex_fwd_load;
    assign hazard    = ex_fwd_valid && ex_fwd_we && ex_fwd_load && ex_fwd_rd != REG_ZERO &&
                       (ex_fwd_rd == dec.rs1 || (!dec.i && ex_fwd_rd == dec.rs2));
    assign adv       = !out_valid || out_ready;
    assign dec.ready = adv && !hazard && !flush;
    assign op_b      = dec.i ? sign_extend_simm(dec.simm) : byp_b;

    operand_bypass_mux u_byp_a (
        .idx(dec.rs1), .rf_data(rf_pa), .ex_en(ex_alu), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .op(op_a)
    );

    operand_bypass_mux u_byp_b (
        .idx(dec.rs2), .rf_data(rf_pb), .ex_en(ex_alu), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .op(byp_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op_a  <= '0;
            out_op_b  <= '0;
            out_rd    <= '0;
            out_ctrl  <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (adv && dec.valid && !hazard) begin
                out_valid <= 1'b1;
                out_op_a  <= op_a;
                out_op_b  <= op_b;
                out_rd    <= dec.rd;
                out_ctrl  <= dec.ctrl;
            end else if (adv) begin
                out_valid <= 1'b0;
            end
            if (dec.valid && hazard && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule
